// File: rtl/cpu_pkg.sv
// Shared types and constants for the SimpleProcessor control unit:
// opcodes, FSM state encoding, ALU codes and instruction field positions.
package cpu_pkg;

  localparam int PC_W = 7;
  localparam int IR_W = 16;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_e;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD_A = 4'd3,
    ST_LOAD_B = 4'd4,
    ST_STORE  = 4'd5,
    ST_ADD    = 4'd6,
    ST_SUB    = 4'd7,
    ST_HALT   = 4'd8
  } state_e;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int DADDR_MSB = 11;
  localparam int DADDR_LSB = 4;
  localparam int RA_MSB    = 11;
  localparam int RA_LSB    = 8;
  localparam int RB_MSB    = 7;
  localparam int RB_LSB    = 4;
  localparam int RD_MSB    = 3;
  localparam int RD_LSB    = 0;

  // Unused opcodes (0110-1111) fall back to FETCH, i.e. execute as NOOP.
  function automatic state_e decode_next(input logic [3:0] op);
    state_e nxt;
    case (op)
      OP_LOAD:  nxt = ST_LOAD_A;
      OP_STORE: nxt = ST_STORE;
      OP_ADD:   nxt = ST_ADD;
      OP_SUB:   nxt = ST_SUB;
      OP_HALT:  nxt = ST_HALT;
      default:  nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Instruction program counter: async active-low clear, increments when
// enabled and wraps naturally at 2^PC_W.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // PC register with wrap-around increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore controller: fetches from a synchronous ROM, decodes the
// instruction register and sequences the Datapath control lines.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = cpu_pkg::PC_W,
  parameter int IR_W = cpu_pkg::IR_W
) (
  input  logic            Clk,
  input  logic            ResetN,
  output logic [PC_W-1:0] PC_Addr,
  input  logic [IR_W-1:0] IR_Data,
  output logic [2:0]      ALUSelect,
  output logic [7:0]      DAddr,
  output logic [3:0]      ReadAddrA,
  output logic [3:0]      ReadAddrB,
  output logic [3:0]      WriteAddr,
  output logic            RFSelect,
  output logic            RF_W_En,
  output logic            RAM_En,
  output logic            Halted,
  output logic [3:0]      StateOut,
  output logic [IR_W-1:0] IROut
);

  state_e          r_state;
  logic [IR_W-1:0] r_ir;
  logic            w_pc_inc;
  logic [PC_W-1:0] w_pc;

  assign w_pc_inc = (r_state == ST_FETCH);

  program_counter #(.PC_W(PC_W)) u_pc (
    .i_clk   (Clk),
    .i_rst_n (ResetN),
    .i_inc   (w_pc_inc),
    .o_pc    (w_pc)
  );

  // State sequencing and instruction register capture
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_INIT;
      r_ir    <= '0;
    end else begin
      case (r_state)
        ST_INIT:   r_state <= ST_FETCH;
        ST_FETCH:  r_state <= ST_DECODE;
        ST_DECODE: begin
          r_ir    <= IR_Data;
          r_state <= decode_next(IR_Data[OP_MSB:OP_LSB]);
        end
        ST_LOAD_A: r_state <= ST_LOAD_B;
        ST_LOAD_B: r_state <= ST_FETCH;
        ST_STORE:  r_state <= ST_FETCH;
        ST_ADD:    r_state <= ST_FETCH;
        ST_SUB:    r_state <= ST_FETCH;
        ST_HALT:   r_state <= ST_HALT;
        default:   r_state <= ST_INIT;
      endcase
    end
  end

  // Moore output decode; enables fall with the async state reset
  always_comb begin
    ALUSelect = ALU_NONE;
    DAddr     = 8'd0;
    ReadAddrA = 4'd0;
    ReadAddrB = 4'd0;
    WriteAddr = 4'd0;
    RFSelect  = 1'b0;
    RF_W_En   = 1'b0;
    RAM_En    = 1'b0;
    Halted    = 1'b0;
    case (r_state)
      ST_LOAD_A: begin
        DAddr    = r_ir[DADDR_MSB:DADDR_LSB];
        RFSelect = 1'b1;
      end
      ST_LOAD_B: begin
        DAddr     = r_ir[DADDR_MSB:DADDR_LSB];
        RFSelect  = 1'b1;
        WriteAddr = r_ir[RD_MSB:RD_LSB];
        RF_W_En   = 1'b1;
      end
      ST_STORE: begin
        DAddr     = r_ir[DADDR_MSB:DADDR_LSB];
        ReadAddrA = r_ir[RD_MSB:RD_LSB];
        RAM_En    = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        ReadAddrA = r_ir[RA_MSB:RA_LSB];
        ReadAddrB = r_ir[RB_MSB:RB_LSB];
        WriteAddr = r_ir[RD_MSB:RD_LSB];
        ALUSelect = (r_state == ST_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_En   = 1'b1;
      end
      ST_HALT: Halted = 1'b1;
      default: Halted = 1'b0;
    endcase
  end

  assign PC_Addr  = w_pc;
  assign StateOut = r_state;
  assign IROut    = r_ir;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a synchronous ROM model feeds the DUT
// and an instruction-level reference model predicts every cycle's outputs.
module tb_control_unit;
  import cpu_pkg::*;

  logic        Clk;
  logic        ResetN;
  logic [6:0]  PC_Addr;
  logic [15:0] IR_Data;
  logic [2:0]  ALUSelect;
  logic [7:0]  DAddr;
  logic [3:0]  ReadAddrA, ReadAddrB, WriteAddr;
  logic        RFSelect, RF_W_En, RAM_En, Halted;
  logic [3:0]  StateOut;
  logic [15:0] IROut;

  int total = 0;
  int bad   = 0;

  logic [15:0] rom [128];
  logic [49:0] exp_q[$];

  control_unit dut (
    .Clk(Clk), .ResetN(ResetN), .PC_Addr(PC_Addr), .IR_Data(IR_Data),
    .ALUSelect(ALUSelect), .DAddr(DAddr), .ReadAddrA(ReadAddrA),
    .ReadAddrB(ReadAddrB), .WriteAddr(WriteAddr), .RFSelect(RFSelect),
    .RF_W_En(RF_W_En), .RAM_En(RAM_En), .Halted(Halted),
    .StateOut(StateOut), .IROut(IROut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) IR_Data <= rom[PC_Addr];

  function automatic logic [49:0] pack(input logic [6:0] pc, input logic [2:0] alu,
      input logic [7:0] da, input logic [3:0] ra, input logic [3:0] rb,
      input logic [3:0] wa, input logic rfs, input logic rfw, input logic ram,
      input logic hlt, input logic [15:0] ir);
    return {pc, alu, da, ra, rb, wa, rfs, rfw, ram, hlt, ir};
  endfunction

  function automatic logic [49:0] observe();
    return pack(PC_Addr, ALUSelect, DAddr, ReadAddrA, ReadAddrB, WriteAddr,
                RFSelect, RF_W_En, RAM_En, Halted, IROut);
  endfunction

  // Instruction-level model: each instruction expands into its cycle sequence.
  task automatic build_model(input int n);
    int pc;
    logic [15:0] ir, cur;
    exp_q.delete();
    pc  = 0;
    cur = 16'h0000;
    exp_q.push_back(pack(7'(pc), 3'd0, 8'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, cur));
    while (exp_q.size() < n) begin
      ir = rom[pc];
      exp_q.push_back(pack(7'(pc), 3'd0, 8'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, cur));
      pc = (pc + 1) % 128;
      exp_q.push_back(pack(7'(pc), 3'd0, 8'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, cur));
      cur = ir;
      case (ir[15:12])
        4'd1: exp_q.push_back(pack(7'(pc), 3'd0, ir[11:4], ir[3:0], 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ir));
        4'd2: begin
          exp_q.push_back(pack(7'(pc), 3'd0, ir[11:4], 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, ir));
          exp_q.push_back(pack(7'(pc), 3'd0, ir[11:4], 4'd0, 4'd0, ir[3:0], 1'b1, 1'b1, 1'b0, 1'b0, ir));
        end
        4'd3: exp_q.push_back(pack(7'(pc), 3'd1, 8'd0, ir[11:8], ir[7:4], ir[3:0], 1'b0, 1'b1, 1'b0, 1'b0, ir));
        4'd4: exp_q.push_back(pack(7'(pc), 3'd2, 8'd0, ir[11:8], ir[7:4], ir[3:0], 1'b0, 1'b1, 1'b0, 1'b0, ir));
        4'd5: while (exp_q.size() < n)
          exp_q.push_back(pack(7'(pc), 3'd0, 8'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, ir));
        default: ;
      endcase
    end
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 128; i++) rom[i] = w;
  endtask

  task automatic apply_reset();
    ResetN = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    ResetN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
    ResetN = 1'b0;
    @(negedge Clk);
    #1;
    total++;
    if (observe() !== 50'd0 || StateOut !== ST_INIT) begin
      bad++;
      $display("FAIL reset got=%h state=%0d exp=0 state=%0d", observe(), StateOut, ST_INIT);
    end
  endtask

  task automatic test_load();
    fill_rom(16'h0000);
    rom[0] = 16'h21A0;
    rom[1] = 16'h22B1;
    build_model(14);
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      if (i > 0) begin @(negedge Clk); #1; end
      total++;
      if (observe() !== exp_q[i]) begin
        bad++;
        $display("FAIL load cyc=%0d got=%h exp=%h", i, observe(), exp_q[i]);
      end
    end
  endtask

  task automatic test_alu();
    fill_rom(16'h0000);
    rom[0] = 16'h3012;
    rom[1] = 16'h4013;
    build_model(10);
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(negedge Clk); #1; end
      total++;
      if (observe() !== exp_q[i]) begin
        bad++;
        $display("FAIL alu cyc=%0d got=%h exp=%h", i, observe(), exp_q[i]);
      end
    end
  endtask

  task automatic test_store();
    fill_rom(16'h0000);
    rom[0] = 16'h1013;
    build_model(8);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(negedge Clk); #1; end
      total++;
      if (observe() !== exp_q[i]) begin
        bad++;
        $display("FAIL store cyc=%0d got=%h exp=%h", i, observe(), exp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    fill_rom(16'h0000);
    rom[1] = 16'hF000;
    rom[3] = 16'h6ABC;
    rom[6] = 16'h5000;
    rom[7] = 16'h21A0;
    build_model(35);
    apply_reset();
    for (int i = 0; i < 35; i++) begin
      if (i > 0) begin @(negedge Clk); #1; end
      total++;
      if (observe() !== exp_q[i]) begin
        bad++;
        $display("FAIL halt cyc=%0d got=%h exp=%h", i, observe(), exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] op;
    for (int i = 0; i < 128; i++) begin
      op = 4'($urandom_range(5, 15));
      if (op == 4'd5) op = 4'd0;
      rom[i] = {op, 12'($urandom)};
    end
    build_model(261);
    apply_reset();
    for (int i = 0; i < 261; i++) begin
      if (i > 0) begin @(negedge Clk); #1; end
      total++;
      if (observe() !== exp_q[i]) begin
        bad++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", i, observe(), exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 128; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd5) op = 4'd3;
      rom[i] = {op, 12'($urandom)};
    end
    build_model(300);
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if (i > 0) begin @(negedge Clk); #1; end
      total++;
      if (observe() !== exp_q[i] || (RF_W_En && RAM_En)) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, observe(), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    fill_rom(16'h0000);
    rom[0] = 16'h21A0;
    apply_reset();
    repeat (4) @(negedge Clk);
    #1;
    total++;
    if (RF_W_En !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre rfwe=%b exp=1", RF_W_En);
    end
    ResetN = 1'b0;
    #1;
    total++;
    if (RF_W_En !== 1'b0 || RFSelect !== 1'b0 || PC_Addr !== 7'd0 || StateOut !== ST_INIT) begin
      bad++;
      $display("FAIL midreset_async rfwe=%b rfsel=%b pc=%0d state=%0d exp 0 0 0 %0d",
               RF_W_En, RFSelect, PC_Addr, StateOut, ST_INIT);
    end
    @(negedge Clk);
    ResetN = 1'b1;
    #1;
    total++;
    if (StateOut !== ST_INIT || PC_Addr !== 7'd0) begin
      bad++;
      $display("FAIL midreset_init state=%0d pc=%0d exp %0d 0", StateOut, PC_Addr, ST_INIT);
    end
    @(negedge Clk);
    #1;
    total++;
    if (StateOut !== ST_FETCH || PC_Addr !== 7'd0) begin
      bad++;
      $display("FAIL midreset_fetch state=%0d pc=%0d exp %0d 0", StateOut, PC_Addr, ST_FETCH);
    end
  endtask

  initial begin
    ResetN = 1'b0;
    fill_rom(16'h0000);
    test_reset();
    test_load();
    test_alu();
    test_store();
    test_halt();
    test_wrap();
    test_random();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle controller for the SimpleProcessor; the issuing end of the Datapath control interface.
- Fetches 16-bit instructions from a synchronous instruction ROM using a program counter.
- Decodes each instruction and sequences the Datapath control lines (ALU select, RAM address/enable, RF read/write addresses, write-back mux select, RF write enable) through a Moore state machine.
- Sits between the instruction ROM and Datapath in the processor top level.

Parameters:
- PC_W, 7, program counter and instruction-ROM address width (128 words).
- IR_W, 16, instruction width.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- ResetN  input  1  asynchronous active-low reset.
- PC_Addr  output  PC_W  instruction ROM address (current PC).
- IR_Data  input  IR_W  instruction ROM read data; valid one cycle after PC_Addr is sampled.
- ALUSelect  output  3  ALU operation code to Datapath.
- DAddr  output  8  data RAM address to Datapath.
- ReadAddrA  output  4  RF read port A address.
- ReadAddrB  output  4  RF read port B address.
- WriteAddr  output  4  RF write address.
- RFSelect  output  1  RF write-data mux select: 1 = RAM data, 0 = ALU result.
- RF_W_En  output  1  RF write enable.
- RAM_En  output  1  data RAM write enable.
- Halted  output  1  high while in HALT.
- StateOut  output  4  current state encoding (debug).
- IROut  output  IR_W  instruction register (debug).

Behaviour:
- Instruction encoding, opcode IR[15:12]:
  - NOOP 0000.
  - STORE 0001: RAM[IR[11:4]] <= RF[IR[3:0]].
  - LOAD 0010: RF[IR[3:0]] <= RAM[IR[11:4]].
  - ADD 0011: RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]].
  - SUB 0100: same fields as ADD, subtract.
  - HALT 0101.
  - Opcodes 0110-1111 execute as NOOP.
- States: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Reset (async, ResetN=0):
  - State=INIT, PC=0, IR=0.
  - All outputs 0: ALUSelect=0, DAddr=0, read/write addresses=0, RFSelect=0, RF_W_En=0, RAM_En=0, Halted=0.
  - Reset asserted mid-instruction aborts it immediately; the enables drop asynchronously.
- Outputs are combinational from state and IR only (Moore). Every output not listed for a state is 0.
- INIT: one cycle, then FETCH.
- FETCH:
  - PC_Addr=PC (PC_Addr always equals PC).
  - At the edge: PC <= PC+1, modulo 2^PC_W (127 wraps to 0). Next state DECODE.
- DECODE:
  - IR <= IR_Data at the edge.
  - Next state is taken from IR_Data[15:12]: LOAD->LOAD_A, STORE->STORE, ADD->ADD, SUB->SUB, HALT->HALT, otherwise FETCH.
- LOAD_A: DAddr=IR[11:4], RFSelect=1, RF_W_En=0 (RAM read latency cycle); next LOAD_B.
- LOAD_B: DAddr=IR[11:4], RFSelect=1, WriteAddr=IR[3:0], RF_W_En=1; next FETCH.
- STORE: DAddr=IR[11:4], ReadAddrA=IR[3:0], RAM_En=1; next FETCH.
- ADD: ReadAddrA=IR[11:8], ReadAddrB=IR[7:4], WriteAddr=IR[3:0], ALUSelect=3'd1, RFSelect=0, RF_W_En=1; next FETCH.
- SUB: same as ADD with ALUSelect=3'd2.
- HALT: Halted=1, no enables asserted, PC frozen; leaves only by reset.
- Cycle counts per instruction: LOAD 4, ADD/SUB/STORE 3, NOOP 2.
- RF_W_En and RAM_En are never both 1. Each is asserted for exactly one cycle per instruction.

Decomposition:
- Package cpu_pkg holds:
  - opcode enum (OP_NOOP..OP_HALT).
  - state enum (4-bit).
  - ALU codes ALU_ADD=3'd1, ALU_SUB=3'd2.
  - IR field bit-position constants.
- One sub-module, program_counter: async active-low clear, increment enable, PC_W-bit wrap.
- FSM, IR register and output decode stay in control_unit.

Test Plan:
- Reset mid-LOAD_B (ResetN=0 while RF_W_En=1) -> RF_W_En=0 immediately; PC=0 and StateOut=INIT after release; FETCH follows one cycle later.
- ROM {0x21A0, 0x22B1} -> each LOAD takes 4 cycles; in LOAD_B, DAddr=0x1A, WriteAddr=0, RFSelect=1, RF_W_En=1, then DAddr=0x2B, WriteAddr=1.
- ADD 0x3012 then SUB 0x4013 -> ReadAddrA=0, ReadAddrB=1, RF_W_En=1; WriteAddr=2 with ALUSelect=1, then WriteAddr=3 with ALUSelect=2; each 3 cycles.
- STORE 0x1013 -> one cycle with RAM_En=1, DAddr=0x01, ReadAddrA=3, RF_W_En=0.
- HALT 0x5000 at word 6 -> Halted=1, PC holds at 7 and all enables stay 0 for 20 cycles; opcode 0xF000 executes as 2-cycle NOOP.
- 128 NOOP words -> PC wraps 127->0 and fetch of word 0 repeats.
